usb_rx_packet_ctrl: RTL and testbench

USB_RX_PACKET_CTRL -- requirements
Module: usb_rx_packet_ctrl

---
 rtl/usb_pkg.sv | 44 ++++
 rtl/usb_pid_decode.sv | 21 ++
 rtl/usb_rx_packet_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_usb_rx_packet_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive packet controller.
// Holds the FSM state encoding, PID nibbles, PID classes and report error codes.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HSHK,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_SYNC = 3'd1,
        ERR_PID  = 3'd2,
        ERR_LEN  = 3'd3,
        ERR_RCV  = 3'd4,
        ERR_OVF  = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_TOKEN,
        CLS_DATA,
        CLS_HSHK
    } pid_class_e;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [6:0] MAX_PAYLOAD = 7'd64;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

endpackage

// File: rtl/usb_pid_decode.sv
// Combinational PID byte decoder: checks the complement nibble and
// classifies the PID into token, data or handshake.
module usb_pid_decode
    import usb_pkg::*;
(
    input  logic [7:0] pid_byte,
    output logic       pid_valid,
    output pid_class_e pid_class
);

    always_comb begin
        pid_valid = (pid_byte[7:4] == ~pid_byte[3:0]);
        case (pid_byte[3:0])
            PID_OUT, PID_SOF, PID_IN, PID_SETUP: pid_class = CLS_TOKEN;
            PID_DATA0, PID_DATA1:                pid_class = CLS_DATA;
            PID_ACK, PID_NAK, PID_STALL:         pid_class = CLS_HSHK;
            default:                             pid_class = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet controller: parses sync/PID, strips the CRC bytes of
// data packets through a 2-byte delay line and reports each packet once.
module usb_rx_packet_ctrl
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       write_enable,
    input  logic       rcv_error,
    input  logic       eop,
    output logic       packet_type,
    output logic [7:0] fifo_wdata,
    output logic       fifo_wen,
    input  logic       fifo_full,
    output logic [3:0] pkt_pid,
    output logic [6:0] pkt_len,
    output logic       pkt_valid,
    output logic [2:0] pkt_err,
    input  logic       pkt_ack,
    output logic       busy
);

    state_e     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic [7:0] d_old_reg, d_old_next;
    logic [7:0] d_new_reg, d_new_next;
    logic [6:0] len_reg, len_next;
    logic [3:0] pid_reg, pid_next;
    logic       drain_reg, drain_next;

    logic       packet_type_reg, packet_type_next;
    logic [7:0] fifo_wdata_reg, fifo_wdata_next;
    logic       fifo_wen_reg, fifo_wen_next;
    logic [3:0] pkt_pid_reg, pkt_pid_next;
    logic [6:0] pkt_len_reg, pkt_len_next;
    logic       pkt_valid_reg, pkt_valid_next;
    err_e       pkt_err_reg, pkt_err_next;
    logic       busy_reg, busy_next;

    logic       fail;
    logic       done_ok;
    err_e       err_code;
    logic       pid_valid;
    pid_class_e pid_class;

    usb_pid_decode u_pid_decode (
        .pid_byte  (rx_data),
        .pid_valid (pid_valid),
        .pid_class (pid_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            d_old_reg       <= '0;
            d_new_reg       <= '0;
            len_reg         <= '0;
            pid_reg         <= '0;
            drain_reg       <= 1'b0;
            packet_type_reg <= 1'b0;
            fifo_wdata_reg  <= '0;
            fifo_wen_reg    <= 1'b0;
            pkt_pid_reg     <= '0;
            pkt_len_reg     <= '0;
            pkt_valid_reg   <= 1'b0;
            pkt_err_reg     <= ERR_NONE;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            d_old_reg       <= d_old_next;
            d_new_reg       <= d_new_next;
            len_reg         <= len_next;
            pid_reg         <= pid_next;
            drain_reg       <= drain_next;
            packet_type_reg <= packet_type_next;
            fifo_wdata_reg  <= fifo_wdata_next;
            fifo_wen_reg    <= fifo_wen_next;
            pkt_pid_reg     <= pkt_pid_next;
            pkt_len_reg     <= pkt_len_next;
            pkt_valid_reg   <= pkt_valid_next;
            pkt_err_reg     <= pkt_err_next;
            busy_reg        <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        d_old_next      = d_old_reg;
        d_new_next      = d_new_reg;
        len_next        = len_reg;
        pid_next        = pid_reg;
        drain_next      = drain_reg & ~eop;
        fifo_wen_next   = 1'b0;
        fifo_wdata_next = fifo_wdata_reg;
        pkt_pid_next    = pkt_pid_reg;
        pkt_len_next    = pkt_len_reg;
        pkt_err_next    = pkt_err_reg;
        done_ok         = 1'b0;
        err_code        = ERR_NONE;
        // Receiver errors pre-empt everything else while a packet is open
        fail            = rcv_error && (state_reg != ST_IDLE) && (state_reg != ST_DONE);
        if (fail) err_code = ERR_RCV;

        if (state_reg == ST_DONE && pkt_ack) state_next = ST_IDLE;

        if (write_enable && !fail) begin
            case (state_reg)
                ST_IDLE: if (!drain_reg) begin
                    cnt_next   = '0;
                    len_next   = '0;
                    pid_next   = '0;
                    d_old_next = '0;
                    d_new_next = '0;
                    if (rx_data == SYNC_BYTE) state_next = ST_PID;
                    else begin fail = 1'b1; err_code = ERR_SYNC; end
                end
                ST_PID: begin
                    pid_next = rx_data[3:0];
                    if (!pid_valid) begin fail = 1'b1; err_code = ERR_PID; end
                    else begin
                        case (pid_class)
                            CLS_TOKEN: state_next = ST_TOKEN;
                            CLS_DATA:  state_next = ST_DATA;
                            CLS_HSHK:  state_next = ST_HSHK;
                            default:   begin fail = 1'b1; err_code = ERR_PID; end
                        endcase
                    end
                end
                ST_TOKEN: begin
                    if (cnt_reg == 2'd2) begin fail = 1'b1; err_code = ERR_LEN; end
                    else cnt_next = cnt_reg + 2'd1;
                end
                ST_HSHK: begin fail = 1'b1; err_code = ERR_LEN; end
                ST_DATA: begin
                    // Only once two bytes are held is the oldest one known not to be CRC
                    if (cnt_reg != 2'd2) cnt_next = cnt_reg + 2'd1;
                    else if (len_reg == MAX_PAYLOAD) begin fail = 1'b1; err_code = ERR_LEN; end
                    else if (fifo_full) begin fail = 1'b1; err_code = ERR_OVF; end
                    else begin
                        fifo_wen_next   = 1'b1;
                        fifo_wdata_next = d_old_reg;
                        len_next        = len_reg + 7'd1;
                    end
                    if (!fail) begin
                        d_old_next = d_new_reg;
                        d_new_next = rx_data;
                    end
                end
                default: ;
            endcase
        end

        // eop is judged against the state as updated by a same-cycle byte
        if (eop && !fail) begin
            case (state_next)
                ST_PID: begin fail = 1'b1; err_code = ERR_LEN; end
                ST_TOKEN, ST_DATA: begin
                    if (cnt_next == 2'd2) done_ok = 1'b1;
                    else begin fail = 1'b1; err_code = ERR_LEN; end
                end
                ST_HSHK: done_ok = 1'b1;
                default: ;
            endcase
        end

        if (fail) begin
            state_next = ST_DONE;
            drain_next = ~eop;
        end else if (done_ok) begin
            state_next = ST_DONE;
        end

        if (state_reg != ST_DONE && state_next == ST_DONE) begin
            pkt_pid_next = pid_next;
            pkt_len_next = len_next;
            pkt_err_next = err_code;
        end

        packet_type_next = (state_next == ST_DATA);
        pkt_valid_next   = (state_next == ST_DONE);
        busy_next        = (state_next != ST_IDLE);
    end

    assign packet_type = packet_type_reg;
    assign fifo_wdata  = fifo_wdata_reg;
    assign fifo_wen    = fifo_wen_reg;
    assign pkt_pid     = pkt_pid_reg;
    assign pkt_len     = pkt_len_reg;
    assign pkt_valid   = pkt_valid_reg;
    assign pkt_err     = pkt_err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Bench for usb_rx_packet_ctrl: directed and random packets checked against
// a byte-list reference model of the packet rules.
module tb_usb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       write_enable = 1'b0;
    logic       rcv_error = 1'b0;
    logic       eop = 1'b0;
    logic       packet_type;
    logic [7:0] fifo_wdata;
    logic       fifo_wen;
    logic       fifo_full = 1'b0;
    logic [3:0] pkt_pid;
    logic [6:0] pkt_len;
    logic       pkt_valid;
    logic [2:0] pkt_err;
    logic       pkt_ack = 1'b0;
    logic       busy;

    usb_rx_packet_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .write_enable (write_enable),
        .rcv_error    (rcv_error),
        .eop          (eop),
        .packet_type  (packet_type),
        .fifo_wdata   (fifo_wdata),
        .fifo_wen     (fifo_wen),
        .fifo_full    (fifo_full),
        .pkt_pid      (pkt_pid),
        .pkt_len      (pkt_len),
        .pkt_valid    (pkt_valid),
        .pkt_err      (pkt_err),
        .pkt_ack      (pkt_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    byte unsigned pkt_q[$];
    int           rcv_at;
    int           full_at;
    bit           eop_last;

    byte unsigned got_q[$];
    int           pt_cnt = 0;

    byte unsigned exp_q[$];
    int           exp_err, exp_pid, exp_len;
    bit           exp_pt;

    always @(negedge clk) begin
        if (fifo_wen === 1'b1) got_q.push_back(fifo_wdata);
        if (packet_type === 1'b1) pt_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input byte unsigned b, input bit rerr, input bit full, input bit e);
        rx_data      = b;
        write_enable = 1'b1;
        rcv_error    = rerr;
        fifo_full    = full;
        eop          = e;
        tick();
        write_enable = 1'b0;
        rcv_error    = 1'b0;
        eop          = 1'b0;
        rx_data      = '0;
    endtask

    // Reference: walk the byte list applying the packet rules, stop at first error.
    function automatic void model();
        int          cls;
        int          n;
        int          w;
        byte unsigned b;
        exp_err = 0; exp_pid = 0; exp_len = 0; exp_pt = 0; cls = 0;
        exp_q.delete();
        if (pkt_q[0] != 8'h80) begin exp_err = 1; return; end
        for (int i = 1; i < pkt_q.size(); i++) begin
            b = pkt_q[i];
            if (i == rcv_at) begin exp_err = 4; return; end
            if (i == 1) begin
                exp_pid = int'(b[3:0]);
                if (b[3:0] inside {4'h1, 4'h5, 4'h9, 4'hD}) cls = 1;
                else if (b[3:0] inside {4'h3, 4'hB}) cls = 2;
                else if (b[3:0] inside {4'h2, 4'hA, 4'hE}) cls = 3;
                if (((b[7:4] ^ b[3:0]) != 4'hF) || cls == 0) begin exp_err = 2; return; end
                if (cls == 2) exp_pt = 1;
            end else begin
                n = i - 1;
                if (cls == 3) begin exp_err = 3; return; end
                if (cls == 1 && n > 2) begin exp_err = 3; return; end
                if (cls == 2) begin
                    w = n - 2;
                    if (w >= 1) begin
                        if (w > 64) begin exp_err = 3; return; end
                        if (full_at != 0 && w >= full_at) begin exp_err = 5; return; end
                        exp_q.push_back(pkt_q[i - 2]);
                        exp_len++;
                    end
                end
            end
        end
        if (pkt_q.size() < 2) begin exp_err = 3; return; end
        if ((cls == 1 || cls == 2) && (pkt_q.size() - 2) < 2) exp_err = 3;
    endfunction

    task automatic run_pkt(input string tag, input int hold);
        int base;
        int ptb;
        int cyc;
        model();
        base = got_q.size();
        ptb  = pt_cnt;
        foreach (pkt_q[i]) begin
            repeat ($urandom_range(0, 2)) tick();
            drive_byte(pkt_q[i], (i == rcv_at), (full_at != 0 && i >= full_at + 3),
                       eop_last && (i == pkt_q.size() - 1));
        end
        if (!eop_last) begin
            repeat ($urandom_range(0, 2)) tick();
            eop = 1'b1;
            tick();
            eop = 1'b0;
        end
        fifo_full = 1'b0;
        cyc = 0;
        while (pkt_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
        check({tag, "_err"}, 32'(pkt_err), 32'(exp_err));
        check({tag, "_pid"}, 32'(pkt_pid), 32'(exp_pid));
        check({tag, "_len"}, 32'(pkt_len), 32'(exp_len));
        check({tag, "_ptype_done"}, 32'(packet_type), 32'd0);
        check({tag, "_ptype_seen"}, 32'(pt_cnt > ptb), 32'(exp_pt));
        check({tag, "_nwrites"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (base + k < got_q.size())
                check({tag, "_wdata"}, 32'(got_q[base + k]), 32'(exp_q[k]));
        end
        repeat (hold) tick();
        check({tag, "_held"}, 32'(pkt_valid), 32'd1);
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        check({tag, "_acked_valid"}, 32'(pkt_valid), 32'd0);
        check({tag, "_acked_busy"}, 32'(busy), 32'd0);
        $display("packet %s: bytes=%0d err=%0d pid=%0h len=%0d", tag, pkt_q.size(), exp_err, exp_pid, exp_len);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wen"}, 32'(fifo_wen), 32'd0);
        check({tag, "_wdata"}, 32'(fifo_wdata), 32'd0);
        check({tag, "_valid"}, 32'(pkt_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ptype"}, 32'(packet_type), 32'd0);
        check({tag, "_len"}, 32'(pkt_len), 32'd0);
        check({tag, "_err"}, 32'(pkt_err), 32'd0);
        check({tag, "_pid"}, 32'(pkt_pid), 32'd0);
    endtask

    function automatic void gen_random();
        logic [3:0] lo;
        int         extra;
        pkt_q.delete();
        rcv_at = -1; full_at = 0; eop_last = 0;
        if ($urandom_range(0, 9) == 0) begin
            pkt_q.push_back(8'($urandom_range(0, 127)));
        end else begin
            pkt_q.push_back(8'h80);
            lo = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) pkt_q.push_back(8'($urandom_range(0, 255)));
            else pkt_q.push_back({~lo, lo});
        end
        extra = $urandom_range(0, 8);
        repeat (extra) pkt_q.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) == 0) rcv_at = $urandom_range(1, pkt_q.size() - 1);
        if ($urandom_range(0, 4) == 0) full_at = $urandom_range(1, 4);
        eop_last = (pkt_q.size() >= 3) && ($urandom_range(0, 2) == 0);
    endfunction

    initial begin
        rcv_at = -1; full_at = 0; eop_last = 0;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        pkt_q = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
        run_pkt("data0", 0);

        pkt_q = '{8'h80, 8'h69, 8'h12, 8'h34};
        run_pkt("token_in", 1);

        pkt_q = '{8'h80, 8'hD2};
        run_pkt("ack", 0);

        pkt_q = '{8'h80, 8'hD3, 8'h01};
        run_pkt("bad_pid", 0);

        pkt_q = '{8'h7F, 8'hC3, 8'h01};
        run_pkt("bad_sync", 0);

        pkt_q = '{8'h80, 8'hE1, 8'h12};
        run_pkt("token_short", 0);

        pkt_q = '{8'h80, 8'hE1, 8'h12, 8'h34, 8'h56};
        run_pkt("token_long", 0);

        pkt_q = '{8'h80, 8'hD2, 8'h00};
        run_pkt("hshk_byte", 0);

        pkt_q = '{8'h80, 8'h4B, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC1, 8'hC2};
        full_at = 2;
        run_pkt("data1_full", 0);
        full_at = 0;

        pkt_q = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        rcv_at = 5;
        run_pkt("rcv_err", 0);
        rcv_at = -1;

        pkt_q = '{8'h80, 8'h4B, 8'hAA, 8'hBB};
        run_pkt("data_empty", 0);

        pkt_q = '{8'h80, 8'hC3};
        for (int i = 0; i < 69; i++) pkt_q.push_back(8'(i + 1));
        run_pkt("data_67", 10);

        pkt_q = '{8'h80, 8'hE1, 8'h12, 8'h34};
        eop_last = 1;
        run_pkt("token_eop_same", 0);
        eop_last = 0;

        // Reset while a FIFO write is on the port
        pkt_q = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33};
        foreach (pkt_q[i]) drive_byte(pkt_q[i], 1'b0, 1'b0, 1'b0);
        check("rst_pre_wen", 32'(fifo_wen), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        tick();
        pkt_q = '{8'h80, 8'h4B, 8'h5A, 8'h6B, 8'h01, 8'h02};
        run_pkt("after_rst", 0);

        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_pkt($sformatf("rand%0d", r), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
